decode_cycle: RTL and testbench

ID stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage. Consumes InstrD/PCD/PCPlus4D and decodes control signals. Holds the 32x32 register file, which is written from WB with same-cycle write-through bypass. Generates the sign-extended immediate and latches everything into the ID/EX register, which supports flush (bubble) insertion from the hazard unit.

---
 rtl/decode_cycle.sv | 238 +++++++++++++++++++++++
 tb/tb_decode_cycle.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, 32x32 register file with WB write-through
// bypass, immediate generation and the flushable ID/EX pipeline register.
module decode_cycle #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            flushE,
  output logic [4:0]      RS1_D,
  output logic [4:0]      RS2_D,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcAE,
  output logic            ALUSrcBE,
  output logic [3:0]      ALUControlE,
  output logic [2:0]      funct3E,
  output logic            IllegalE,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      RS1_E,
  output logic [4:0]      RS2_E,
  output logic [4:0]      RD_E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_OR  = 4'h3,
    ALU_XOR = 4'h4, ALU_SLT = 4'h5, ALU_SLTU = 4'h6, ALU_SLL = 4'h7,
    ALU_SRL = 4'h8, ALU_SRA = 4'h9, ALU_PASSB = 4'hA
  } alu_e;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src_a;
    logic            alu_src_b;
    logic [3:0]      alu_ctl;
    logic [2:0]      funct3;
    logic            illegal;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } idex_t;

  // alt selects SUB/SRA; callers gate it so only legal encodings reach here
  function automatic alu_e alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_sel = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_sel = ALU_SLL;
      3'b010:  alu_sel = ALU_SLT;
      3'b011:  alu_sel = ALU_SLTU;
      3'b100:  alu_sel = ALU_XOR;
      3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  endfunction

  logic [XLEN-1:0] regs [NREGS];
  logic [6:0]      opcode_p0;
  logic [2:0]      funct3_p0;
  logic [4:0]      rd_p0;
  logic [XLEN-1:0] rd1_p0, rd2_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic            reg_write_p0, mem_write_p0, jump_p0, branch_p0;
  logic            alu_src_a_p0, alu_src_b_p0, illegal_p0;
  logic [1:0]      result_src_p0;
  alu_e            alu_ctl_p0;
  logic            wb_en;
  idex_t           idex_d, idex_p1;

  assign opcode_p0 = InstrD[6:0];
  assign funct3_p0 = InstrD[14:12];
  assign rd_p0     = InstrD[11:7];
  assign RS1_D     = InstrD[19:15];
  assign RS2_D     = InstrD[24:20];
  assign wb_en     = RegWriteW && (RDW != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[RDW] <= ResultW;
    end
  end

  // x0 is never written, so regs[0] reads zero without a special case
  assign rd1_p0 = (wb_en && RDW == RS1_D) ? ResultW : regs[RS1_D];
  assign rd2_p0 = (wb_en && RDW == RS2_D) ? ResultW : regs[RS2_D];

  always_comb begin
    reg_write_p0  = 1'b0;
    result_src_p0 = 2'b00;
    mem_write_p0  = 1'b0;
    jump_p0       = 1'b0;
    branch_p0     = 1'b0;
    alu_src_a_p0  = 1'b0;
    alu_src_b_p0  = 1'b0;
    alu_ctl_p0    = ALU_ADD;
    illegal_p0    = 1'b0;
    imm_p0        = '0;
    case (opcode_p0)
      OP_R: begin
        reg_write_p0 = 1'b1;
        alu_ctl_p0   = alu_sel(funct3_p0, InstrD[30]);
      end
      OP_I: begin
        reg_write_p0 = 1'b1;
        alu_src_b_p0 = 1'b1;
        alu_ctl_p0   = alu_sel(funct3_p0, InstrD[30] && funct3_p0 == 3'b101);
        imm_p0       = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      end
      OP_LOAD: begin
        reg_write_p0  = 1'b1;
        result_src_p0 = 2'b01;
        alu_src_b_p0  = 1'b1;
        imm_p0        = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      end
      OP_STORE: begin
        mem_write_p0 = 1'b1;
        alu_src_b_p0 = 1'b1;
        imm_p0       = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      end
      OP_BR: begin
        branch_p0  = 1'b1;
        alu_ctl_p0 = ALU_SUB;
        imm_p0     = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      end
      OP_JAL: begin
        jump_p0       = 1'b1;
        reg_write_p0  = 1'b1;
        result_src_p0 = 2'b10;
        alu_src_a_p0  = 1'b1;
        alu_src_b_p0  = 1'b1;
        imm_p0 = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      end
      OP_JALR: begin
        jump_p0       = 1'b1;
        reg_write_p0  = 1'b1;
        result_src_p0 = 2'b10;
        alu_src_b_p0  = 1'b1;
        imm_p0        = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      end
      OP_LUI: begin
        reg_write_p0 = 1'b1;
        alu_src_b_p0 = 1'b1;
        alu_ctl_p0   = ALU_PASSB;
        imm_p0       = {{(XLEN-32){InstrD[31]}}, InstrD[31:12], 12'b0};
      end
      OP_AUIPC: begin
        reg_write_p0 = 1'b1;
        alu_src_a_p0 = 1'b1;
        alu_src_b_p0 = 1'b1;
        imm_p0       = {{(XLEN-32){InstrD[31]}}, InstrD[31:12], 12'b0};
      end
      default: illegal_p0 = 1'b1;
    endcase
  end

  always_comb begin
    idex_d            = '0;
    idex_d.reg_write  = reg_write_p0;
    idex_d.result_src = result_src_p0;
    idex_d.mem_write  = mem_write_p0;
    idex_d.jump       = jump_p0;
    idex_d.branch     = branch_p0;
    idex_d.alu_src_a  = alu_src_a_p0;
    idex_d.alu_src_b  = alu_src_b_p0;
    idex_d.alu_ctl    = alu_ctl_p0;
    idex_d.funct3     = funct3_p0;
    idex_d.illegal    = illegal_p0;
    idex_d.rd1        = rd1_p0;
    idex_d.rd2        = rd2_p0;
    idex_d.imm        = imm_p0;
    idex_d.rs1        = RS1_D;
    idex_d.rs2        = RS2_D;
    idex_d.rd         = rd_p0;
    idex_d.pc         = PCD;
    idex_d.pc_plus4   = PCPlus4D;
  end

  // ID -> EX boundary; a flush leaves an all-zero bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        idex_p1 <= '0;
    else if (flushE) idex_p1 <= '0;
    else             idex_p1 <= idex_d;
  end

  assign RegWriteE   = idex_p1.reg_write;
  assign ResultSrcE  = idex_p1.result_src;
  assign MemWriteE   = idex_p1.mem_write;
  assign JumpE       = idex_p1.jump;
  assign BranchE     = idex_p1.branch;
  assign ALUSrcAE    = idex_p1.alu_src_a;
  assign ALUSrcBE    = idex_p1.alu_src_b;
  assign ALUControlE = idex_p1.alu_ctl;
  assign funct3E     = idex_p1.funct3;
  assign IllegalE    = idex_p1.illegal;
  assign RD1_E       = idex_p1.rd1;
  assign RD2_E       = idex_p1.rd2;
  assign ImmExtE     = idex_p1.imm;
  assign RS1_E       = idex_p1.rs1;
  assign RS2_E       = idex_p1.rs2;
  assign RD_E        = idex_p1.rd;
  assign PCE         = idex_p1.pc;
  assign PCPlus4E    = idex_p1.pc_plus4;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: a decode vector table plus hand sequences
// for reset, WB bypass, x0 protection and flush bubbles.
module tb_decode_cycle;

  logic        clk, rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, flushE;
  logic [4:0]  RDW;
  logic [4:0]  RS1_D, RS2_D, RS1_E, RS2_E, RD_E;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcAE, ALUSrcBE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  funct3E;
  logic [31:0] RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .flushE(flushE),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .ALUSrcAE(ALUSrcAE),
    .ALUSrcBE(ALUSrcBE), .ALUControlE(ALUControlE), .funct3E(funct3E),
    .IllegalE(IllegalE), .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExtE(ImmExtE),
    .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_chk  = 0;
  int n_fail = 0;

  logic [190:0] all_e;
  assign all_e = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcAE, ALUSrcBE,
                  ALUControlE, funct3E, IllegalE, RD1_E, RD2_E, ImmExtE,
                  RS1_E, RS2_E, RD_E, PCE, PCPlus4E};

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
    @(negedge clk);
    RegWriteW = 1'b1; RDW = r; ResultW = v;
    @(posedge clk);
    @(negedge clk);
    RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'h0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        rw;
    logic [1:0]  rsrc;
    logic        mw, jmp, br, asa, asb;
    logic [3:0]  alu;
    logic        ill;
    logic        chk_imm;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] rd1, rd2;
  } vec_t;

  vec_t tbl [17];

  initial begin
    // register state assumed by the table: x1, x2, x5 preloaded, all others 0
    tbl[0]  = '{32'h00528333, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0,        5'd6,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[1]  = '{32'h402081B3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 32'h0,        5'd3,  32'h11111111, 32'h22222222};
    tbl[2]  = '{32'h4020D233, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h9, 1'b0, 1'b0, 32'h0,        5'd4,  32'h11111111, 32'h22222222};
    tbl[3]  = '{32'h0020B233, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0, 32'h0,        5'd4,  32'h11111111, 32'h22222222};
    tbl[4]  = '{32'hC0008393, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 32'hFFFFFC00, 5'd7,  32'h11111111, 32'h0};
    tbl[5]  = '{32'h40D0D093, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 1'b0, 1'b1, 32'h0000040D, 5'd1,  32'h11111111, 32'h0};
    tbl[6]  = '{32'h00412403, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 32'h00000004, 5'd8,  32'h22222222, 32'h0};
    tbl[7]  = '{32'h00112023, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 32'h0,        5'd0,  32'h22222222, 32'h11111111};
    tbl[8]  = '{32'hFE010EE3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 1'b1, 32'hFFFFFFFC, 5'd29, 32'h22222222, 32'h0};
    tbl[9]  = '{32'hFFDFF0EF, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 32'hFFFFFFFC, 5'd1,  32'h0,        32'h0};
    tbl[10] = '{32'h008280E7, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 32'h00000008, 5'd1,  32'hDEADBEEF, 32'h0};
    tbl[11] = '{32'h123452B7, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 32'h12345000, 5'd5,  32'h0,        32'h0};
    tbl[12] = '{32'hFFFFF497, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 32'hFFFFF000, 5'd9,  32'h0,        32'h0};
    tbl[13] = '{32'h0000007F, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 32'h0,        5'd0,  32'h0,        32'h0};
    tbl[14] = '{32'h00000000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 32'h0,        5'd0,  32'h0,        32'h0};
    tbl[15] = '{32'h00000013, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 32'h0,        5'd0,  32'h0,        32'h0};
    tbl[16] = '{32'hFFF0C513, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 1'b0, 1'b1, 32'hFFFFFFFF, 5'd10, 32'h11111111, 32'h0};

    rst = 1'b0; InstrD = 32'h00000013; PCD = 32'h0; PCPlus4D = 32'h4;
    RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'h0; flushE = 1'b0;
    step();
    step();
    check("reset_outputs", all_e, '0);
    @(negedge clk);
    rst = 1'b1;

    wb_write(5'd1, 32'h11111111);
    wb_write(5'd2, 32'h22222222);
    wb_write(5'd5, 32'hDEADBEEF);

    for (int i = 0; i < 17; i++) begin
      logic [31:0] pc;
      pc = 32'h1000 + 32'(i * 4);
      @(negedge clk);
      InstrD = tbl[i].instr; PCD = pc; PCPlus4D = pc + 32'd4;
      #1;
      check($sformatf("rs_d[%0d]", i), {RS1_D, RS2_D}, {tbl[i].instr[19:15], tbl[i].instr[24:20]});
      step();
      check($sformatf("ctl[%0d]", i),
            {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcAE, ALUSrcBE, ALUControlE, IllegalE},
            {tbl[i].rw, tbl[i].rsrc, tbl[i].mw, tbl[i].jmp, tbl[i].br, tbl[i].asa, tbl[i].asb, tbl[i].alu, tbl[i].ill});
      if (tbl[i].chk_imm) check($sformatf("imm[%0d]", i), ImmExtE, tbl[i].imm);
      check($sformatf("rd[%0d]", i), RD_E, tbl[i].rd);
      check($sformatf("rd1[%0d]", i), RD1_E, tbl[i].rd1);
      check($sformatf("rd2[%0d]", i), RD2_E, tbl[i].rd2);
      check($sformatf("idx[%0d]", i), {RS1_E, RS2_E, funct3E},
            {tbl[i].instr[19:15], tbl[i].instr[24:20], tbl[i].instr[14:12]});
      check($sformatf("pc[%0d]", i), {PCE, PCPlus4E}, {pc, pc + 32'd4});
    end

    // same-cycle WB bypass of x5, then the stored value on a later read
    @(negedge clk);
    InstrD = 32'h00528333; RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'h12345678;
    step();
    check("bypass_rd1", RD1_E, 32'h12345678);
    check("bypass_rd2", RD2_E, 32'h12345678);
    @(negedge clk);
    RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'h0;
    step();
    check("stored_x5", RD1_E, 32'h12345678);

    // write to x0 is neither bypassed nor stored
    @(negedge clk);
    InstrD = 32'h00000333; RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'hFFFFFFFF;
    step();
    check("x0_bypass", {RD1_E, RD2_E}, 64'h0);
    @(negedge clk);
    RegWriteW = 1'b0; ResultW = 32'h0;
    step();
    check("x0_stored", {RD1_E, RD2_E}, 64'h0);

    // flushed store with a concurrent WB write to x3
    @(negedge clk);
    InstrD = 32'h00112023; PCD = 32'h2000; PCPlus4D = 32'h2004; flushE = 1'b1;
    RegWriteW = 1'b1; RDW = 5'd3; ResultW = 32'hCAFEF00D;
    step();
    check("flush_bubble", all_e, '0);
    @(negedge clk);
    flushE = 1'b0; RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'h0;
    step();
    check("post_flush_mw", {MemWriteE, ImmExtE}, {1'b1, 32'h0});
    @(negedge clk);
    InstrD = 32'h00318333;
    step();
    check("flush_wb_x3", RD1_E, 32'hCAFEF00D);
    @(negedge clk);
    InstrD = 32'h0000007F; flushE = 1'b1;
    step();
    check("flush_illegal", IllegalE, 1'b0);
    @(negedge clk);
    flushE = 1'b0;
    step();
    check("illegal_latched", {IllegalE, RegWriteE, MemWriteE}, 3'b100);

    // asynchronous reset between edges, held across an edge
    @(negedge clk);
    InstrD = 32'h00528333;
    step();
    check("pre_reset_x5", RD1_E, 32'h12345678);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", all_e, '0);
    step();
    check("reset_held", all_e, '0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("x5_after_reset", {RD1_E, RegWriteE, RD_E}, {32'h0, 1'b1, 5'd6});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
